// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, memory-handshake states and the shadow stage slot shared by the MIPS pipeline control.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic       valid;
        logic       load;
        logic       store;
        logic       writereg;
        logic [4:0] dest;
    } slot_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the EX-stage load and the ID instruction's sources.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_load,
    input  logic [4:0] ex_dest,
    input  logic       id_valid,
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    logic uses_rt;

    assign uses_rt = (id_op == OP_RTYPE) | (id_op == OP_BEQ) | (id_op == OP_BNE) | (id_op == OP_SW);

    // r0 is hardwired to zero, so a load into it never creates a dependency
    assign hazard = id_valid & ex_valid & ex_load & (ex_dest != 5'd0) &
                    ((ex_dest == id_rs) | (uses_rt & (ex_dest == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enables, bubbles and flushes for load-use, branch and jump hazards,
// plus the MEM-stage request/ack handshake that freezes the pipe during data accesses.
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       id_valid,
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_dest,
    input  logic       id_writereg,
    input  logic       id_readmem,
    input  logic       id_writemem,
    input  logic       ex_branch_taken,
    input  logic       mem_ack,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_err
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    slot_t      ex_slot;
    slot_t      mem_slot;
    mem_state_t state;
    logic [7:0] cnt;
    logic       hazard;
    logic       mem_pend;
    logic       freeze;
    logic       stall;
    logic       jump;

    hazard_detect u_hazard (
        .ex_valid (ex_slot.valid),
        .ex_load  (ex_slot.load),
        .ex_dest  (ex_slot.dest),
        .id_valid (id_valid),
        .id_op    (id_op),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .hazard   (hazard)
    );

    assign mem_pend = mem_slot.valid & (mem_slot.load | mem_slot.store);
    // the access must not slip out of MEM before the FSM has latched it into REQ
    assign freeze   = (state == MEM_REQ) | ((state == MEM_IDLE) & mem_pend);
    assign stall    = hazard & ~ex_branch_taken;
    assign jump     = id_valid & (id_op == OP_J);

    assign pc_en       = ~freeze & ~stall;
    assign ifid_en     = ~freeze & ~stall;
    assign idex_en     = ~freeze;
    assign exmem_en    = ~freeze;
    assign ifid_flush  = ~freeze & (ex_branch_taken | (jump & ~hazard));
    assign idex_bubble = ~freeze & (ex_branch_taken | hazard);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_slot  <= '0;
            mem_slot <= '0;
        end else begin
            if (exmem_en) mem_slot <= ex_slot;
            if (idex_en) ex_slot <= idex_bubble ? '0 :
                slot_t'({id_valid, id_readmem, id_writemem, id_writereg, id_dest});
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MEM_IDLE;
            cnt     <= 8'd0;
            mem_err <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: if (mem_pend) begin
                    state   <= MEM_REQ;
                    cnt     <= 8'd0;
                    mem_req <= 1'b1;
                    mem_we  <= mem_slot.store;
                end
                MEM_REQ: if (mem_ack || cnt == TO_LAST) begin
                    state   <= MEM_DONE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (!mem_ack) mem_err <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table, hand-written memory sequences and a randomized run
// against an abstract pipeline model for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
    import mips_pkg::*;

    localparam int TO = 6;

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       wr;
        logic       rd;
        logic       wm;
    } ins_t;

    typedef struct {
        ins_t       i;
        logic       br;
        logic       ack;
        logic [7:0] exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    ins_t       cur = '0;
    logic       br = 1'b0;
    logic       ack = 1'b0;
    logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, mem_req, mem_we, mem_err;
    logic [7:0] outs;
    int         n_tests = 0;
    int         n_fail = 0;
    vec_t       tv[19];

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, mem_req, mem_we};

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .id_valid        (cur.v),
        .id_op           (cur.op),
        .id_rs           (cur.rs),
        .id_rt           (cur.rt),
        .id_dest         (cur.dest),
        .id_writereg     (cur.wr),
        .id_readmem      (cur.rd),
        .id_writemem     (cur.wm),
        .ex_branch_taken (br),
        .mem_ack         (ack),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_err         (mem_err)
    );

    function automatic ins_t mk(logic v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] dest, logic wr, logic rd, logic wm);
        return '{v, op, rs, rt, dest, wr, rd, wm};
    endfunction
    function automatic ins_t lw(logic [4:0] rs, logic [4:0] rt);
        return mk(1, OP_LW, rs, rt, rt, 1, 1, 0);
    endfunction
    function automatic ins_t sw(logic [4:0] rs, logic [4:0] rt);
        return mk(1, OP_SW, rs, rt, 5'd0, 0, 0, 1);
    endfunction
    function automatic ins_t add(logic [4:0] d, logic [4:0] s, logic [4:0] t);
        return mk(1, OP_RTYPE, s, t, d, 1, 0, 0);
    endfunction
    function automatic ins_t jmp();
        return mk(1, OP_J, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input ins_t i, input logic b, input logic a, input logic [7:0] exp, input string name);
        cur = i;
        br  = b;
        ack = a;
        @(negedge clock);
        chk(name, outs, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        cur     = '0;
        br      = 1'b0;
        ack     = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // abstract model: two-entry shadow pipe plus a memory engine tracked as busy/done flags and a wait count
    typedef struct { bit v; bit ld; bit st; int dest; } rec_t;
    rec_t m_ex, m_mem;
    bit   m_req, m_done, m_err;
    int   m_wait;

    function automatic logic [7:0] model_out(ins_t i, logic b, output bit frz, output bit bub);
        bit mem_op, urt, lu, jp, stl;
        mem_op = m_mem.v && (m_mem.ld || m_mem.st);
        frz    = m_req || (!m_done && mem_op);
        urt    = i.op inside {6'd0, 6'd4, 6'd5, 6'd43};
        lu     = i.v && m_ex.v && m_ex.ld && m_ex.dest != 0 &&
                 (m_ex.dest == int'(i.rs) || (urt && m_ex.dest == int'(i.rt)));
        jp     = i.v && i.op == 6'd2;
        stl    = lu && !b;
        bub    = !frz && (b || lu);
        if (frz) return {6'b0, m_req, m_req && m_mem.st};
        return {!stl, !stl, 1'b1, 1'b1, b || (jp && !lu), b || lu, 2'b00};
    endfunction

    task automatic model_clock(ins_t i, logic a, bit frz, bit bub);
        bit mem_op;
        mem_op = m_mem.v && (m_mem.ld || m_mem.st);
        if (m_req) begin
            m_wait++;
            if (a) begin m_req = 0; m_done = 1; end
            else if (m_wait == TO) begin m_req = 0; m_done = 1; m_err = 1; end
        end else if (m_done) m_done = 0;
        else if (mem_op) begin m_req = 1; m_wait = 0; end
        if (!frz) begin
            m_mem = m_ex;
            m_ex  = bub ? '{0, 0, 0, 0} : '{i.v, i.rd, i.wm, int'(i.dest)};
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[7];
        ops = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd35, 6'd43, 6'd8};

        tv[0]  = '{lw(1, 5),      0, 1, 8'b1111_00_00};
        tv[1]  = '{add(6, 5, 1),  0, 1, 8'b0011_01_00};
        tv[2]  = '{add(6, 5, 1),  0, 1, 8'b0000_00_00};
        tv[3]  = '{add(6, 5, 1),  0, 1, 8'b0000_00_10};
        tv[4]  = '{add(6, 5, 1),  0, 1, 8'b1111_00_00};
        tv[5]  = '{ins_t'(0),     0, 1, 8'b1111_00_00};
        tv[6]  = '{lw(1, 0),      0, 1, 8'b1111_00_00};
        tv[7]  = '{add(6, 0, 0),  0, 1, 8'b1111_00_00};
        tv[8]  = '{ins_t'(0),     0, 1, 8'b0000_00_00};
        tv[9]  = '{ins_t'(0),     0, 1, 8'b0000_00_10};
        tv[10] = '{ins_t'(0),     0, 1, 8'b1111_00_00};
        tv[11] = '{ins_t'(0),     0, 1, 8'b1111_00_00};
        tv[12] = '{lw(1, 7),      0, 1, 8'b1111_00_00};
        tv[13] = '{add(6, 7, 1),  1, 1, 8'b1111_11_00};
        tv[14] = '{ins_t'(0),     0, 1, 8'b0000_00_00};
        tv[15] = '{ins_t'(0),     0, 1, 8'b0000_00_10};
        tv[16] = '{jmp(),         0, 1, 8'b1111_10_00};
        tv[17] = '{jmp(),         1, 1, 8'b1111_11_00};
        tv[18] = '{ins_t'(0),     0, 1, 8'b1111_00_00};

        do_reset();
        @(negedge clock);
        chk("reset_outs", outs, 8'b1111_00_00);
        chk("reset_err", {7'b0, mem_err}, 8'd0);
        @(posedge clock);
        #1;
        for (int k = 0; k < 19; k++) step(tv[k].i, tv[k].br, tv[k].ack, tv[k].exp, $sformatf("vec%0d", k));

        // store with ack held off for four REQ cycles
        do_reset();
        step(sw(2, 3),    0, 0, 8'b1111_00_00, "sw_id");
        step(ins_t'(0),   0, 0, 8'b1111_00_00, "sw_ex");
        step(ins_t'(0),   0, 0, 8'b0000_00_00, "sw_enter");
        for (int k = 0; k < 4; k++) step(ins_t'(0), 0, 0, 8'b0000_00_11, "sw_wait");
        step(ins_t'(0),   0, 1, 8'b0000_00_11, "sw_ack");
        step(ins_t'(0),   0, 0, 8'b1111_00_00, "sw_done");
        step(ins_t'(0),   0, 1, 8'b1111_00_00, "sw_idle_ack_ignored");
        chk("sw_err", {7'b0, mem_err}, 8'd0);

        // load that never gets acked
        do_reset();
        step(lw(1, 4),    0, 0, 8'b1111_00_00, "to_id");
        step(ins_t'(0),   0, 0, 8'b1111_00_00, "to_ex");
        step(ins_t'(0),   0, 0, 8'b0000_00_00, "to_enter");
        for (int k = 0; k < TO; k++) step(ins_t'(0), 0, 0, 8'b0000_00_10, "to_wait");
        chk("to_err_rise", {7'b0, mem_err}, 8'd1);
        step(ins_t'(0),   0, 0, 8'b1111_00_00, "to_done");
        step(ins_t'(0),   0, 0, 8'b1111_00_00, "to_resume");
        chk("to_err_sticky", {7'b0, mem_err}, 8'd1);

        // asynchronous reset in the middle of REQ
        do_reset();
        step(lw(1, 4),    0, 0, 8'b1111_00_00, "rst_id");
        step(ins_t'(0),   0, 0, 8'b1111_00_00, "rst_ex");
        step(ins_t'(0),   0, 0, 8'b0000_00_00, "rst_enter");
        step(ins_t'(0),   0, 0, 8'b0000_00_10, "rst_req");
        reset_n = 1'b0;
        #1;
        chk("rst_async", outs, 8'b1111_00_00);
        #1 reset_n = 1'b1;
        step(add(6, 4, 4), 0, 0, 8'b1111_00_00, "rst_ex_empty");
        step(ins_t'(0),    0, 0, 8'b1111_00_00, "rst_mem_empty");
        chk("rst_err", {7'b0, mem_err}, 8'd0);

        // randomized run against the abstract model
        do_reset();
        m_ex = '{0, 0, 0, 0};
        m_mem = '{0, 0, 0, 0};
        m_req = 0; m_done = 0; m_err = 0; m_wait = 0;
        for (int n = 0; n < 800; n++) begin
            ins_t i;
            logic b, a;
            logic [7:0] e;
            bit frz, bub;
            i.op   = ops[$urandom_range(0, 6)];
            i.v    = $urandom_range(0, 3) != 0;
            i.rs   = 5'($urandom_range(0, 3));
            i.rt   = 5'($urandom_range(0, 3));
            i.dest = 5'($urandom_range(0, 3));
            i.rd   = i.op == OP_LW;
            i.wm   = i.op == OP_SW;
            i.wr   = i.op == OP_RTYPE || i.op == OP_LW || i.op == 6'd8;
            b      = $urandom_range(0, 7) == 0;
            a      = $urandom_range(0, 4) == 0;
            e      = model_out(i, b, frz, bub);
            cur = i; br = b; ack = a;
            @(negedge clock);
            chk($sformatf("rand%0d", n), outs, e);
            chk($sformatf("rand_err%0d", n), {7'b0, mem_err}, {7'b0, m_err});
            @(posedge clock);
            model_clock(i, a, frz, bub);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
